riscv_mem_arbiter: RTL and testbench
====================================

Name: riscv_mem_arbiter

Overview:
Shares one single-port synchronous memory between the instruction-fetch stage and the data-memory stage of the 5-stage core. It arbitrates between the two requesters and sequences each memory transaction through issue, wait and completion. It also generates the stall requests that the hazard unit ORs into its StallF/StallD and pipeline-hold logic. Data accesses have priority over fetch, with a bounded-starvation guarantee for fetch.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables = DATA_W/8)
MEM_LAT, 2, cycles from mem_en cycle to mem_rdata valid; legal range 1..15
STARVE_MAX, 4, max consecutive data grants while if_req is pending; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, level, held until if_valid
if_addr  in  ADDR_W  fetch address, stable while if_req
if_flush  in  1  drop any in-flight fetch result (from PC redirect)
if_valid  out  1  one-cycle fetch completion
if_rdata  out  DATA_W  fetch data, valid with if_valid
d_req  in  1  data request, level, held until d_valid
d_we  in  1  1 = store
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  byte enables
d_valid  out  1  one-cycle data completion
d_rdata  out  DATA_W  load data, valid with d_valid
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data
stall_if  out  1  fetch waiting (= if_req & ~if_valid)
stall_mem  out  1  data access waiting (= d_req & ~d_valid)

Behaviour:
- Clock and reset: one clock clk. Reset rst_n is asynchronous, active-low. While rst_n is low, all registered outputs, state, counters and the owner flag are 0, and state is IDLE. Reset mid-transaction discards that transaction; no valid is produced for it.
- FSM states are IDLE -> ISSUE -> WAIT -> DONE -> IDLE. At most one transaction is outstanding.
- IDLE: arbitration happens only in this state.
  - Grant D if d_req and (starve_cnt < STARVE_MAX or !if_req).
  - Otherwise grant I if if_req.
  - Otherwise remain in IDLE.
  - On a grant: latch the address, write data, byte enables and we into the mem_* registers, record the owner, and go to ISSUE.
- ISSUE: lasts 1 cycle. mem_en = 1. mem_we = latched we (0 for fetch). Load the latency counter with MEM_LAT-1, then go to WAIT.
- WAIT: the counter decrements each cycle. In the cycle the counter is 0, mem_rdata is valid: capture it into the owner's rdata register (capture 0 for stores), then go to DONE.
- mem_en and mem_we are 0 in every state other than ISSUE. mem_addr, mem_wdata and mem_be hold their values until the next grant.
- DONE: lasts 1 cycle.
  - Owner D: assert d_valid.
  - Owner I: assert if_valid unless the flushed flag is set.
  - Then go to IDLE. Requests are not sampled in DONE, so the completing requester can present its next request in the following cycle.
- Total latency, request seen in IDLE at cycle T: mem_en at T+1, valid at T+2+MEM_LAT, next arbitration at T+3+MEM_LAT.
- starve_cnt: increments on each D grant while if_req = 1, saturating at STARVE_MAX. It clears on an I grant, or on a D grant with if_req = 0.
- if_flush: if it is high in any cycle from ISSUE through DONE of an I transaction, set the flushed flag. The transaction still runs to completion and the FSM timing is unchanged, but if_valid is suppressed. The flag clears in IDLE. if_flush has no effect on D transactions or in IDLE.
- if_rdata and d_rdata hold their last captured value between valids.
- stall_if and stall_mem are combinational from the inputs and the valid outputs.
- A request that arrives while the FSM is not in IDLE waits. Address alignment is not checked.

Test Plan:
1. MEM_LAT=2: if_req at cycle 0 with if_addr=0x100; memory returns 0x00500093 at cycle 3 -> mem_en is high only in cycle 1, if_valid is high in cycle 4 with if_rdata=0x00500093, and stall_if is high in cycles 0-3 and low in cycle 4.
2. if_req and d_req both at cycle 0 (d_we=0, d_addr=0x2000) -> mem_addr=0x2000 in cycle 1 and d_valid in cycle 4. The fetch is granted in cycle 5, with mem_en in cycle 6 and if_valid in cycle 9.
3. Store with d_we=1, d_be=4'b0011, d_addr=0x2004, d_wdata=0xDEADBEEF -> in ISSUE: mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF. d_valid is asserted in DONE with d_rdata=0.
4. STARVE_MAX=2, with if_req and d_req held high continuously -> grant sequence is D, D, I, D, D, I.
5. if_flush pulsed during WAIT of a fetch -> no if_valid; the FSM returns to IDLE at the normal cycle, and the next if_req is granted normally.
6. rst_n driven low mid-WAIT of a store -> mem_en, mem_we, d_valid and if_valid are immediately 0 and the state is IDLE. After release, a new d_req completes in MEM_LAT+2 cycles.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and data access.
// Data wins arbitration; a pending fetch is guaranteed a grant after at most STARVE_MAX data grants.
module riscv_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_valid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_if,
    output logic                stall_mem
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              nextState_s;
    logic [3:0]          latCnt_r;
    logic [3:0]          starveCnt_r;
    logic                ownerD_r;
    logic                flushed_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [BE_W-1:0]     be_r;
    logic [DATA_W-1:0]   ifRdata_r;
    logic [DATA_W-1:0]   dRdata_r;
    logic                grantD_s;
    logic                grantI_s;
    logic                capture_s;

    // Grants are only ever decided while idle.
    assign grantD_s  = (state_r == IDLE) && d_req && ((starveCnt_r < STARVE_LIM) || !if_req);
    assign grantI_s  = (state_r == IDLE) && !grantD_s && if_req;
    assign capture_s = (state_r == WAIT) && (latCnt_r == 4'd0);

    // Next-state decode for the transaction sequencer.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (grantD_s || grantI_s) begin
                    nextState_s = ISSUE;
                end else begin
                    nextState_s = IDLE;
                end
            end
            ISSUE: nextState_s = WAIT;
            WAIT: begin
                if (latCnt_r == 4'd0) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = WAIT;
                end
            end
            DONE:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Request latch, owner and starvation tracking, updated on each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            be_r        <= {BE_W{1'b0}};
            we_r        <= 1'b0;
            ownerD_r    <= 1'b0;
            starveCnt_r <= 4'd0;
        end else if (grantD_s) begin
            addr_r      <= d_addr;
            wdata_r     <= d_wdata;
            be_r        <= d_be;
            we_r        <= d_we;
            ownerD_r    <= 1'b1;
            if (!if_req) begin
                starveCnt_r <= 4'd0;
            end else if (starveCnt_r < STARVE_LIM) begin
                starveCnt_r <= starveCnt_r + 4'd1;
            end
        end else if (grantI_s) begin
            // Fetches always read the full word.
            addr_r      <= if_addr;
            wdata_r     <= {DATA_W{1'b0}};
            be_r        <= {BE_W{1'b1}};
            we_r        <= 1'b0;
            ownerD_r    <= 1'b0;
            starveCnt_r <= 4'd0;
        end
    end

    // Latency counter, read-data capture and fetch flush tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latCnt_r  <= 4'd0;
            ifRdata_r <= {DATA_W{1'b0}};
            dRdata_r  <= {DATA_W{1'b0}};
            flushed_r <= 1'b0;
        end else begin
            if (state_r == ISSUE) begin
                latCnt_r <= LAT_INIT;
            end else if ((state_r == WAIT) && (latCnt_r != 4'd0)) begin
                latCnt_r <= latCnt_r - 4'd1;
            end
            if (capture_s && ownerD_r) begin
                dRdata_r <= we_r ? {DATA_W{1'b0}} : mem_rdata;
            end else if (capture_s) begin
                ifRdata_r <= mem_rdata;
            end
            if (state_r == IDLE) begin
                flushed_r <= 1'b0;
            end else if (!ownerD_r && if_flush) begin
                flushed_r <= 1'b1;
            end
        end
    end

    // A flush seen in the completion cycle itself also suppresses the fetch.
    assign if_valid  = (state_r == DONE) && !ownerD_r && !flushed_r && !if_flush;
    assign d_valid   = (state_r == DONE) && ownerD_r;
    assign mem_en    = (state_r == ISSUE);
    assign mem_we    = (state_r == ISSUE) && we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign mem_be    = be_r;
    assign if_rdata  = ifRdata_r;
    assign d_rdata   = dRdata_r;
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req & ~d_valid;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Testbench for riscv_mem_arbiter: directed scenarios plus random traffic, checked against
// a transaction-timing model and a word-level memory image.
module tb_riscv_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int L  = 2;
    localparam int SM = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_flush, if_valid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_valid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [BW-1:0] d_be;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [BW-1:0] mem_be;
    logic          stall_if, stall_mem;

    riscv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memInit(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] be);
        logic [31:0] v;
        v = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
        end
        return v;
    endfunction

    // Environment memory: responds to the DUT's strobes with MEM_LAT cycles of latency.
    logic [31:0] envMem [logic [31:0]];
    logic [31:0] pipe [L];
    assign mem_rdata = pipe[L-1];

    always @(posedge clk) begin
        logic [31:0] v;
        for (int k = L - 1; k > 0; k--) pipe[k] <= pipe[k-1];
        if (mem_en === 1'b1) begin
            v = envMem.exists(mem_addr) ? envMem[mem_addr] : memInit(mem_addr);
            if (mem_we === 1'b1) begin
                envMem[mem_addr] = mergeBytes(v, mem_wdata, mem_be);
                pipe[0] <= $urandom;
            end else begin
                pipe[0] <= v;
            end
        end else begin
            pipe[0] <= $urandom;
        end
    end

    // Reference model: transaction timing from arithmetic on cycle numbers.
    logic [31:0] modMem [logic [31:0]];
    int          cyc = 0;
    int          nextArb = 1;
    int          tIss, tDone;
    int          starve = 0;
    bit          busy = 0, flushed = 0;
    bit          oD, oWe;
    logic [31:0] oAddr, oWdata, oRd;
    logic [3:0]  oBe;
    logic [31:0] lastI = 0, lastD = 0;
    bit          eIfV, eDV, dropIf = 0, dropD = 0;
    bit          grantLog[$];

    task automatic tick();
        @(posedge clk);
        #1;
        if (dropIf) if_req = 1'b0;
        if (dropD)  d_req  = 1'b0;
        dropIf = 0;
        dropD  = 0;
    endtask

    task automatic checkCycle();
        bit eEn;
        logic [31:0] v;
        #1;
        cyc++;
        if (!rst_n) begin
            busy = 0; flushed = 0; starve = 0; nextArb = cyc + 1;
            lastI = 0; lastD = 0; eIfV = 0; eDV = 0;
            expectEq("rst_mem_en", 32'(mem_en), 32'd0);
            expectEq("rst_mem_we", 32'(mem_we), 32'd0);
            expectEq("rst_if_valid", 32'(if_valid), 32'd0);
            expectEq("rst_d_valid", 32'(d_valid), 32'd0);
            expectEq("rst_if_rdata", if_rdata, 32'd0);
            expectEq("rst_d_rdata", d_rdata, 32'd0);
            return;
        end
        if (!busy && cyc == nextArb) begin
            if (d_req && (starve < SM || !if_req)) begin
                oD = 1; oWe = d_we; oAddr = d_addr; oWdata = d_wdata; oBe = d_be;
                starve = if_req ? ((starve < SM) ? starve + 1 : SM) : 0;
            end else if (if_req) begin
                oD = 0; oWe = 0; oAddr = if_addr; oWdata = 0; oBe = 4'hF;
                starve = 0;
            end
            if (d_req || if_req) begin
                busy = 1; flushed = 0;
                tIss = cyc + 1; tDone = cyc + 2 + L; nextArb = cyc + 3 + L;
            end else begin
                nextArb = cyc + 1;
            end
        end
        eEn = busy && (cyc == tIss);
        if (eEn) begin
            v = modMem.exists(oAddr) ? modMem[oAddr] : memInit(oAddr);
            if (oWe) modMem[oAddr] = mergeBytes(v, oWdata, oBe);
            oRd = oWe ? 32'd0 : v;
        end
        if (busy && !oD && cyc >= tIss && cyc <= tDone && if_flush) flushed = 1;
        eIfV = busy && (cyc == tDone) && !oD && !flushed;
        eDV  = busy && (cyc == tDone) && oD;
        expectEq("mem_en", 32'(mem_en), 32'(eEn));
        expectEq("mem_we", 32'(mem_we), 32'(eEn && oWe));
        if (busy && cyc >= tIss) expectEq("mem_addr", mem_addr, oAddr);
        if (eEn && oWe) begin
            expectEq("mem_wdata", mem_wdata, oWdata);
            expectEq("mem_be", 32'(mem_be), 32'(oBe));
        end
        if (busy && cyc == tDone) begin
            if (oD) lastD = oRd;
            else lastI = oRd;
            busy = 0;
        end
        expectEq("if_valid", 32'(if_valid), 32'(eIfV));
        expectEq("d_valid", 32'(d_valid), 32'(eDV));
        expectEq("if_rdata", if_rdata, lastI);
        expectEq("d_rdata", d_rdata, lastD);
        expectEq("stall_if", 32'(stall_if), 32'(if_req && !eIfV));
        expectEq("stall_mem", 32'(stall_mem), 32'(d_req && !eDV));
        if (mem_en === 1'b1) grantLog.push_back(mem_addr == 32'h2008);
        dropIf = eIfV;
        dropD  = eDV;
    endtask

    initial begin
        bit expSeq[6];
        rst_n = 1'b0; if_req = 0; if_addr = 0; if_flush = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        envMem[32'h100] = 32'h0050_0093;
        modMem[32'h100] = 32'h0050_0093;
        for (int k = 0; k < L; k++) pipe[k] = 32'd0;
        repeat (3) begin tick(); checkCycle(); end
        tick(); rst_n = 1'b1; checkCycle();

        // Single fetch timing.
        tick(); if_req = 1; if_addr = 32'h100; checkCycle();
        for (int k = 1; k <= 5; k++) begin
            tick(); checkCycle();
            expectEq("t1_en", 32'(mem_en), 32'(k == 1));
            expectEq("t1_valid", 32'(if_valid), 32'(k == 4));
            if (k <= 4) expectEq("t1_stall", 32'(stall_if), 32'(k < 4));
            if (k == 4) expectEq("t1_rdata", if_rdata, 32'h0050_0093);
        end

        // Simultaneous requests: data first, then fetch.
        tick(); if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h2000; d_be = 4'hF;
        checkCycle();
        for (int k = 1; k <= 10; k++) begin
            tick(); checkCycle();
            if (k == 1) expectEq("t2_addr", mem_addr, 32'h2000);
            expectEq("t2_dvalid", 32'(d_valid), 32'(k == 4));
            expectEq("t2_en", 32'(mem_en), 32'(k == 1 || k == 6));
            expectEq("t2_ivalid", 32'(if_valid), 32'(k == 9));
        end

        // Partial store.
        tick(); d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF;
        checkCycle();
        for (int k = 1; k <= 5; k++) begin
            tick(); checkCycle();
            if (k == 1) begin
                expectEq("t3_we", 32'(mem_we), 32'd1);
                expectEq("t3_be", 32'(mem_be), 32'b0011);
                expectEq("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
            end
            if (k == 4) begin
                expectEq("t3_dvalid", 32'(d_valid), 32'd1);
                expectEq("t3_rdata", d_rdata, 32'd0);
            end
        end

        // Starvation bound with both requesters saturated.
        grantLog.delete();
        d_we = 0; d_be = 4'hF;
        for (int k = 0; k < 6 * (L + 3); k++) begin
            tick();
            if (!if_req) begin if_req = 1; if_addr = 32'h108; end
            if (!d_req) begin d_req = 1; d_addr = 32'h2008; end
            checkCycle();
        end
        expSeq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        expectEq("t4_ngrants", 32'(grantLog.size() >= 6), 32'd1);
        for (int g = 0; g < 6 && g < grantLog.size(); g++)
            expectEq($sformatf("t4_grant%0d", g), 32'(grantLog[g]), 32'(expSeq[g]));
        repeat (2 * (L + 3)) begin tick(); checkCycle(); end

        // Flush during WAIT of a fetch; request stays up and is served again.
        tick(); if_req = 1; if_addr = 32'h10C; checkCycle();
        for (int k = 1; k <= 10; k++) begin
            tick(); if_flush = (k == 2); checkCycle();
            expectEq("t5_en", 32'(mem_en), 32'(k == 1 || k == 6));
            expectEq("t5_valid", 32'(if_valid), 32'(k == 9));
        end
        if_flush = 0;

        // Reset in the middle of a store's WAIT.
        tick(); d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h200C; d_wdata = 32'h1234_5678;
        checkCycle();
        tick(); checkCycle();
        tick(); rst_n = 0; if_req = 0; d_req = 0; checkCycle();
        expectEq("t6_en", 32'(mem_en), 32'd0);
        expectEq("t6_dvalid", 32'(d_valid), 32'd0);
        tick(); checkCycle();
        tick(); rst_n = 1; d_req = 1; d_we = 0; checkCycle();
        for (int k = 1; k <= 5; k++) begin
            tick(); checkCycle();
            expectEq("t6_after", 32'(d_valid), 32'(k == L + 2));
            if (k == L + 2) expectEq("t6_rdata", d_rdata, 32'h1234_5678);
        end

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            tick();
            if (!if_req && $urandom_range(0, 2) != 0) begin
                if_req = 1; if_addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = 32'h2000 + 32'(4 * $urandom_range(0, 7));
                d_wdata = $urandom; d_be = 4'($urandom_range(0, 15));
            end
            if_flush = ($urandom_range(0, 9) == 0) && !(busy && (cyc + 1) == tDone);
            checkCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
